id_stage_fwd: RTL



---
 rtl/id_stage_fwd_pkg.sv | 20 ++
 rtl/id_stage_fwd_if.sv | 91 +++++++++
 rtl/id_stage_fwd_regfile.sv | 70 +++++++
 rtl/id_stage_fwd.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_fwd_pkg.sv
// ----------------------------------------------------------------------------
// id_pkg
// Shared definitions for the decode stage with forwarding:
//   - alu_src operand-mode encodings
//   - default stack-pointer register index and reset value
// ----------------------------------------------------------------------------
package id_pkg;

    // Operand mode selected by the decoder's alu_src field
    typedef enum logic [1:0] {
        ALU_RR  = 2'b00,  // register / register
        ALU_RI  = 2'b01,  // register (or PC for branches) / sign-extended immediate
        ALU_SH  = 2'b10,  // register / shift amount (or +1 for stack ops)
        ALU_SPR = 2'b11   // sprite base / zero-extended A-type immediate
    } alu_src_e;

    localparam int          SP_REG_DEF  = 29;
    localparam logic [31:0] SP_INIT_DEF = 32'h0000_FFFF;

endpackage : id_pkg

// File: rtl/id_stage_fwd_if.sv
// ----------------------------------------------------------------------------
// id_stage_fwd_if
// Bundles every non-clock/reset signal of the decode stage:
//   - IF/ID handshake (in_valid / in_ready) and pipeline control (flush, ex_stall)
//   - decoded control bits, register fields and immediates
//   - writeback port and EX/MEM forwarding sources
//   - registered ID/EX outputs
// master : the surrounding pipeline (drives decode/forwarding inputs)
// slave  : the decode stage itself
// ----------------------------------------------------------------------------
interface id_stage_fwd_if #(
    parameter int DATA_W  = 32,
    parameter int RA_W    = 5,
    parameter int IMM_I_W = 16,
    parameter int IMM_J_W = 26,
    parameter int IMM_A_W = 21
);
    // handshake / pipeline control
    logic               in_valid;
    logic               in_ready;
    logic               flush;
    logic               ex_stall;
    // decode control
    logic               call;
    logic               ret;
    logic               push_pop;
    logic               pop;
    logic               branch;
    logic               reg_2_sel;
    logic               sign_ext_sel;
    logic               mem_write;
    logic               reg_write;
    logic               mem_read;
    logic [1:0]         alu_src;
    logic [RA_W-1:0]    rd;
    logic [RA_W-1:0]    rs;
    logic [RA_W-1:0]    rt;
    logic [4:0]         shamt;
    logic [IMM_I_W-1:0] i_imm;
    logic [IMM_J_W-1:0] j_imm;
    logic [IMM_A_W-1:0] a_imm;
    logic [DATA_W-1:0]  pc_in;
    // writeback
    logic               wb_we;
    logic [RA_W-1:0]    wb_reg;
    logic [DATA_W-1:0]  wb_data;
    // forwarding sources
    logic               ex_we;
    logic               ex_is_load;
    logic [RA_W-1:0]    ex_rd;
    logic [DATA_W-1:0]  ex_data;
    logic               mem_we;
    logic [RA_W-1:0]    mem_rd;
    logic [DATA_W-1:0]  mem_data;
    // ID/EX outputs
    logic               out_valid;
    logic [DATA_W-1:0]  out_alu_a;
    logic [DATA_W-1:0]  out_alu_b;
    logic [DATA_W-1:0]  out_store_data;
    logic [RA_W-1:0]    out_dest;
    logic [IMM_J_W-1:0] out_j_imm;
    logic [DATA_W-1:0]  out_pc;
    logic               out_reg_write;
    logic               out_mem_read;
    logic               out_mem_write;

    modport master (
        output in_valid, flush, ex_stall,
        output call, ret, push_pop, pop, branch, reg_2_sel, sign_ext_sel,
        output mem_write, reg_write, mem_read, alu_src, rd, rs, rt, shamt,
        output i_imm, j_imm, a_imm, pc_in,
        output wb_we, wb_reg, wb_data,
        output ex_we, ex_is_load, ex_rd, ex_data, mem_we, mem_rd, mem_data,
        input  in_ready,
        input  out_valid, out_alu_a, out_alu_b, out_store_data, out_dest,
        input  out_j_imm, out_pc, out_reg_write, out_mem_read, out_mem_write
    );

    modport slave (
        input  in_valid, flush, ex_stall,
        input  call, ret, push_pop, pop, branch, reg_2_sel, sign_ext_sel,
        input  mem_write, reg_write, mem_read, alu_src, rd, rs, rt, shamt,
        input  i_imm, j_imm, a_imm, pc_in,
        input  wb_we, wb_reg, wb_data,
        input  ex_we, ex_is_load, ex_rd, ex_data, mem_we, mem_rd, mem_data,
        output in_ready,
        output out_valid, out_alu_a, out_alu_b, out_store_data, out_dest,
        output out_j_imm, out_pc, out_reg_write, out_mem_read, out_mem_write
    );

endinterface : id_stage_fwd_if

// File: rtl/id_stage_fwd_regfile.sv
// ----------------------------------------------------------------------------
// id_regfile
// 2**RA_W x DATA_W register file, two combinational read ports, one write
// port. Register 0 is hard-wired to zero; the stack-pointer register resets
// to SP_INIT. A read of the register being written this cycle returns the
// write data (write-through).
// Ports:
//   clk, rst             clock, synchronous active-low reset
//   we_i/waddr_i/wdata_i write port
//   raddr1_i/rdata1_o    read port 1
//   raddr2_i/rdata2_o    read port 2
// ----------------------------------------------------------------------------
module id_regfile
    import id_pkg::*;
#(
    parameter int                RA_W    = 5,
    parameter int                DATA_W  = 32,
    parameter int                SP_REG  = SP_REG_DEF,
    parameter logic [DATA_W-1:0] SP_INIT = SP_INIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [RA_W-1:0]   waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [RA_W-1:0]   raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic [RA_W-1:0]   raddr2_i,
    output logic [DATA_W-1:0] rdata2_o
);
    localparam int DEPTH = 2 ** RA_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage: reset image with SP preloaded, then single write port (r0 ignored)
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= (i == SP_REG) ? SP_INIT : {DATA_W{1'b0}};
            end
        end else if (we_i && (waddr_i != {RA_W{1'b0}})) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port 1 with zero register and write-through
    always_comb begin
        rdata1_o = {DATA_W{1'b0}};
        if (raddr1_i == {RA_W{1'b0}}) begin
            rdata1_o = {DATA_W{1'b0}};
        end else if (we_i && (waddr_i == raddr1_i)) begin
            rdata1_o = wdata_i;
        end else begin
            rdata1_o = mem_q[raddr1_i];
        end
    end

    // Read port 2 with zero register and write-through
    always_comb begin
        rdata2_o = {DATA_W{1'b0}};
        if (raddr2_i == {RA_W{1'b0}}) begin
            rdata2_o = {DATA_W{1'b0}};
        end else if (we_i && (waddr_i == raddr2_i)) begin
            rdata2_o = wdata_i;
        end else begin
            rdata2_o = mem_q[raddr2_i];
        end
    end

endmodule : id_regfile

// File: rtl/id_stage_fwd.sv
// ----------------------------------------------------------------------------
// id_stage_fwd
// Decode stage between the IF/ID register and EX: register file read,
// EX/MEM/WB operand forwarding, load-use hazard detection (one bubble per
// load), flush, operand-mode muxing and a registered ID/EX output.
// Ports:
//   clk   clock
//   rst   synchronous active-low reset
//   bus   id_stage_fwd_if.slave: handshake, decode fields, writeback,
//         forwarding sources and ID/EX outputs
// ----------------------------------------------------------------------------
module id_stage_fwd
    import id_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                RA_W        = 5,
    parameter int                SP_REG      = SP_REG_DEF,
    parameter logic [DATA_W-1:0] SP_INIT     = SP_INIT_DEF,
    parameter int                IMM_I_W     = 16,
    parameter int                IMM_J_W     = 26,
    parameter int                IMM_A_W     = 21,
    parameter logic [DATA_W-1:0] SPRITE_BASE = 32'h0000_8000
) (
    input  logic         clk,
    input  logic         rst,
    id_stage_fwd_if.slave bus
);
    // Priority forwarding for one source: EX (non-load) > MEM > WB > regfile
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [RA_W-1:0]   src,
        input logic [DATA_W-1:0] rf_val,
        input logic              ex_we,
        input logic              ex_is_load,
        input logic [RA_W-1:0]   ex_rd,
        input logic [DATA_W-1:0] ex_data,
        input logic              mem_we,
        input logic [RA_W-1:0]   mem_rd,
        input logic [DATA_W-1:0] mem_data,
        input logic              wb_we,
        input logic [RA_W-1:0]   wb_reg,
        input logic [DATA_W-1:0] wb_data
    );
        logic src_nz;
        src_nz = (src != {RA_W{1'b0}});
        if (ex_we && !ex_is_load && (ex_rd == src) && src_nz) begin
            return ex_data;
        end else if (mem_we && (mem_rd == src) && src_nz) begin
            return mem_data;
        end else if (wb_we && (wb_reg == src) && src_nz) begin
            return wb_data;
        end else begin
            return rf_val;
        end
    endfunction

    logic              sp_op_s;
    logic [RA_W-1:0]   src1_s, src2_s;
    logic [DATA_W-1:0] rf1_s, rf2_s;
    logic [DATA_W-1:0] fwd1_s, fwd2_s;
    logic              use1_s, use2_s;
    logic              hazard_s;
    logic [DATA_W-1:0] sext_s;
    logic [DATA_W-1:0] alu_a_s, alu_b_s;

    logic              valid_d, valid_q;
    logic              reg_write_d, reg_write_q;
    logic              mem_read_d, mem_read_q;
    logic              mem_write_d, mem_write_q;
    logic [DATA_W-1:0] alu_a_d, alu_a_q;
    logic [DATA_W-1:0] alu_b_d, alu_b_q;
    logic [DATA_W-1:0] store_d, store_q;
    logic [RA_W-1:0]   dest_d, dest_q;
    logic [IMM_J_W-1:0] j_imm_d, j_imm_q;
    logic [DATA_W-1:0] pc_d, pc_q;

    assign sp_op_s = bus.call | bus.ret | bus.push_pop;
    assign src1_s  = sp_op_s ? RA_W'(SP_REG) : bus.rs;
    assign src2_s  = bus.reg_2_sel ? bus.rt : bus.rd;

    // pop also commits its writeback value through the normal write port
    id_regfile #(
        .RA_W    (RA_W),
        .DATA_W  (DATA_W),
        .SP_REG  (SP_REG),
        .SP_INIT (SP_INIT)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we_i     (bus.wb_we | bus.pop),
        .waddr_i  (bus.wb_reg),
        .wdata_i  (bus.wb_data),
        .raddr1_i (src1_s),
        .rdata1_o (rf1_s),
        .raddr2_i (src2_s),
        .rdata2_o (rf2_s)
    );

    assign fwd1_s = fwd_sel(src1_s, rf1_s, bus.ex_we, bus.ex_is_load, bus.ex_rd, bus.ex_data,
                            bus.mem_we, bus.mem_rd, bus.mem_data, bus.wb_we, bus.wb_reg, bus.wb_data);
    assign fwd2_s = fwd_sel(src2_s, rf2_s, bus.ex_we, bus.ex_is_load, bus.ex_rd, bus.ex_data,
                            bus.mem_we, bus.mem_rd, bus.mem_data, bus.wb_we, bus.wb_reg, bus.wb_data);

    // A load in EX can only be forwarded a cycle later (from MEM), so any
    // consumer of its destination must wait one cycle.
    assign use1_s   = (bus.alu_src != ALU_SPR);
    assign use2_s   = (bus.alu_src == ALU_RR) | bus.mem_write;
    assign hazard_s = bus.in_valid & bus.ex_is_load & bus.ex_we &
                      (bus.ex_rd != {RA_W{1'b0}}) &
                      ((use1_s & (bus.ex_rd == src1_s)) | (use2_s & (bus.ex_rd == src2_s)));

    assign bus.in_ready = rst & ~hazard_s & ~bus.ex_stall;

    assign sext_s = bus.sign_ext_sel ?
                    {{(DATA_W-IMM_J_W){bus.j_imm[IMM_J_W-1]}}, bus.j_imm} :
                    {{(DATA_W-IMM_I_W){bus.i_imm[IMM_I_W-1]}}, bus.i_imm};

    // Operand-mode muxes
    always_comb begin
        alu_a_s = fwd1_s;
        alu_b_s = fwd2_s;
        case (bus.alu_src)
            ALU_RR: begin
                alu_a_s = fwd1_s;
                alu_b_s = fwd2_s;
            end
            ALU_RI: begin
                alu_a_s = bus.branch ? bus.pc_in : fwd1_s;
                alu_b_s = sext_s;
            end
            ALU_SH: begin
                alu_a_s = fwd1_s;
                alu_b_s = sp_op_s ? {{(DATA_W-1){1'b0}}, 1'b1}
                                  : {{(DATA_W-5){1'b0}}, bus.shamt};
            end
            ALU_SPR: begin
                alu_a_s = SPRITE_BASE;
                alu_b_s = {{(DATA_W-IMM_A_W){1'b0}}, bus.a_imm};
            end
            default: begin
                alu_a_s = {DATA_W{1'b0}};
                alu_b_s = {DATA_W{1'b0}};
            end
        endcase
    end

    // ID/EX next state: flush beats stall beats hazard bubble beats load.
    // Payload fields only move when EX can accept; they are don't-care while
    // out_valid is low.
    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        if (bus.flush) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
        end else if (bus.ex_stall) begin
            valid_d     = valid_q;
            reg_write_d = reg_write_q;
            mem_read_d  = mem_read_q;
            mem_write_d = mem_write_q;
        end else if (hazard_s) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
        end else begin
            valid_d     = bus.in_valid;
            reg_write_d = bus.reg_write;
            mem_read_d  = bus.mem_read;
            mem_write_d = bus.mem_write;
        end

        alu_a_d = alu_a_q;
        alu_b_d = alu_b_q;
        store_d = store_q;
        dest_d  = dest_q;
        j_imm_d = j_imm_q;
        pc_d    = pc_q;
        if (!bus.ex_stall) begin
            alu_a_d = alu_a_s;
            alu_b_d = alu_b_s;
            store_d = fwd2_s;
            dest_d  = bus.rd;
            j_imm_d = bus.j_imm;
            pc_d    = bus.pc_in;
        end else begin
            alu_a_d = alu_a_q;
            alu_b_d = alu_b_q;
            store_d = store_q;
            dest_d  = dest_q;
            j_imm_d = j_imm_q;
            pc_d    = pc_q;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            alu_a_q     <= {DATA_W{1'b0}};
            alu_b_q     <= {DATA_W{1'b0}};
            store_q     <= {DATA_W{1'b0}};
            dest_q      <= {RA_W{1'b0}};
            j_imm_q     <= {IMM_J_W{1'b0}};
            pc_q        <= {DATA_W{1'b0}};
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            store_q     <= store_d;
            dest_q      <= dest_d;
            j_imm_q     <= j_imm_d;
            pc_q        <= pc_d;
        end
    end

    assign bus.out_valid      = valid_q;
    assign bus.out_reg_write  = reg_write_q;
    assign bus.out_mem_read   = mem_read_q;
    assign bus.out_mem_write  = mem_write_q;
    assign bus.out_alu_a      = alu_a_q;
    assign bus.out_alu_b      = alu_b_q;
    assign bus.out_store_data = store_q;
    assign bus.out_dest       = dest_q;
    assign bus.out_j_imm      = j_imm_q;
    assign bus.out_pc         = pc_q;

endmodule : id_stage_fwd
